multi_cycle_control_unit: RTL

- Sequencing FSM that converts the existing single-cycle datapath into a multi-cycle CPU.
- Each instruction is stepped through IF/ID/EXE/MEM/WB states. The PC, instruction register, register file and data RAM are enabled only in the state that owns them.
- Replaces the combinational control unit. Sits between the instruction register (opcode) and the ALU zero flag on one side, and all datapath enables and mux selects on the other.

---
 rtl/mcpu_pkg.sv | 47 ++++
 rtl/mcu_op_decode.sv | 57 +++++
 rtl/multi_cycle_control_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mcpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_pkg
// Description : Shared opcodes, state encoding and datapath select constants
//               for the multi-cycle CPU control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mcpu_pkg;

    localparam int c_opW     = 6;
    localparam int c_aluOpW  = 3;

    localparam logic [c_opW-1:0] c_opAdd  = 6'b000000;
    localparam logic [c_opW-1:0] c_opAddi = 6'b000001;
    localparam logic [c_opW-1:0] c_opSub  = 6'b000010;
    localparam logic [c_opW-1:0] c_opOri  = 6'b010000;
    localparam logic [c_opW-1:0] c_opAnd  = 6'b010001;
    localparam logic [c_opW-1:0] c_opOr   = 6'b010010;
    localparam logic [c_opW-1:0] c_opSw   = 6'b100110;
    localparam logic [c_opW-1:0] c_opLw   = 6'b100111;
    localparam logic [c_opW-1:0] c_opBeq  = 6'b110000;
    localparam logic [c_opW-1:0] c_opJ    = 6'b111000;
    localparam logic [c_opW-1:0] c_opHalt = 6'b111111;

    typedef enum logic [3:0] {
        ST_IF     = 4'b0000,
        ST_ID     = 4'b0001,
        ST_EXE_AL = 4'b0010,
        ST_EXE_BR = 4'b0011,
        ST_EXE_MA = 4'b0100,
        ST_MEM    = 4'b0101,
        ST_WB_AL  = 4'b0110,
        ST_WB_LD  = 4'b0111,
        ST_HALT   = 4'b1000
    } state_t;

    localparam logic [c_aluOpW-1:0] c_aluAdd = 3'b000;
    localparam logic [c_aluOpW-1:0] c_aluSub = 3'b001;
    localparam logic [c_aluOpW-1:0] c_aluOr  = 3'b011;
    localparam logic [c_aluOpW-1:0] c_aluAnd = 3'b100;

    localparam logic [1:0] c_pcNext   = 2'b00;
    localparam logic [1:0] c_pcBranch = 2'b01;
    localparam logic [1:0] c_pcJump   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mcu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : mcu_op_decode
// Description : Combinational opcode decoder producing the static datapath
//               fields and a legality flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_op_decode
    import mcpu_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
)
(
    input  logic [OPW-1:0]    i_op,
    output logic [ALUOPW-1:0] o_aluOp,
    output logic              o_aluSrcB,
    output logic              o_regOut,
    output logic              o_extSel,
    output logic              o_legal
);

    always_comb begin
        o_aluOp   = c_aluAdd;
        o_aluSrcB = 1'b0;
        o_regOut  = 1'b0;
        o_extSel  = 1'b1;
        o_legal   = 1'b1;
        case (i_op)
            c_opAdd:  o_regOut = 1'b1;
            c_opAddi: o_aluSrcB = 1'b1;
            c_opSub: begin
                o_aluOp  = c_aluSub;
                o_regOut = 1'b1;
            end
            c_opOri: begin
                o_aluOp   = c_aluOr;
                o_aluSrcB = 1'b1;
                o_extSel  = 1'b0;
            end
            c_opAnd: begin
                o_aluOp  = c_aluAnd;
                o_regOut = 1'b1;
            end
            c_opOr: begin
                o_aluOp  = c_aluOr;
                o_regOut = 1'b1;
            end
            c_opSw, c_opLw: o_aluSrcB = 1'b1;
            c_opBeq:  o_aluOp = c_aluSub;
            c_opJ, c_opHalt: ;
            default:  o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_cycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_control_unit
// Description : IF/ID/EXE/MEM/WB sequencer driving the datapath enables and
//               mux selects of a multi-cycle CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_control_unit
    import mcpu_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [OPW-1:0]    opcode,
    input  logic              zero,
    output logic              PCWre,
    output logic              InsMemRW,
    output logic              IRWre,
    output logic              ExtSel,
    output logic              RegOut,
    output logic              RegWre,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              ALUSrcB,
    output logic              ALUM2Reg,
    output logic [1:0]        PCSrc,
    output logic              DataMemRW,
    output logic [3:0]        state,
    output logic              halted,
    output logic              illegal_op
);

    state_t             r_state;
    logic [OPW-1:0]     r_opQ;
    logic               r_illegal;

    logic [OPW-1:0]     w_decOp;
    logic [ALUOPW-1:0]  w_decAluOp;
    logic               w_decAluSrcB;
    logic               w_decRegOut;
    logic               w_decExtSel;
    logic               w_decLegal;
    logic               w_inExec;
    logic               w_pcWre;
    logic               w_irWre;
    logic               w_regWre;
    logic               w_dataMemRW;

    // In ID the live opcode needs a legality verdict; everywhere else only
    // the captured opcode matters, so one decoder serves both.
    assign w_decOp = (r_state == ST_ID) ? opcode : r_opQ;

    mcu_op_decode #(
        .OPW    (OPW),
        .ALUOPW (ALUOPW)
    ) u_opDecode (
        .i_op      (w_decOp),
        .o_aluOp   (w_decAluOp),
        .o_aluSrcB (w_decAluSrcB),
        .o_regOut  (w_decRegOut),
        .o_extSel  (w_decExtSel),
        .o_legal   (w_decLegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IF;
            r_opQ     <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IF: r_state <= ST_ID;
                ST_ID: begin
                    r_opQ <= opcode;
                    if (!w_decLegal) begin
                        r_illegal <= 1'b1;
                        r_state   <= ST_HALT;
                    end else if (opcode == c_opJ) begin
                        r_state <= ST_IF;
                    end else if (opcode == c_opHalt) begin
                        r_state <= ST_HALT;
                    end else if (opcode == c_opBeq) begin
                        r_state <= ST_EXE_BR;
                    end else if (opcode == c_opLw || opcode == c_opSw) begin
                        r_state <= ST_EXE_MA;
                    end else begin
                        r_state <= ST_EXE_AL;
                    end
                end
                ST_EXE_AL: r_state <= ST_WB_AL;
                ST_EXE_BR: r_state <= ST_IF;
                ST_EXE_MA: r_state <= ST_MEM;
                ST_MEM:    r_state <= (r_opQ == c_opLw) ? ST_WB_LD : ST_IF;
                ST_WB_AL:  r_state <= ST_IF;
                ST_WB_LD:  r_state <= ST_IF;
                ST_HALT:   r_state <= ST_HALT;
                default:   r_state <= ST_IF;
            endcase
        end
    end

    always_comb begin
        w_pcWre     = 1'b0;
        w_irWre     = 1'b0;
        w_regWre    = 1'b0;
        w_dataMemRW = 1'b0;
        InsMemRW    = 1'b0;
        ALUM2Reg    = 1'b0;
        PCSrc       = c_pcNext;
        case (r_state)
            ST_IF: begin
                InsMemRW = 1'b1;
                w_irWre  = 1'b1;
            end
            ST_ID: begin
                if (opcode == c_opJ) begin
                    w_pcWre = 1'b1;
                    PCSrc   = c_pcJump;
                end
            end
            ST_EXE_BR: begin
                w_pcWre = 1'b1;
                PCSrc   = zero ? c_pcBranch : c_pcNext;
            end
            ST_MEM: begin
                if (r_opQ == c_opSw) begin
                    w_dataMemRW = 1'b1;
                    w_pcWre     = 1'b1;
                end
            end
            ST_WB_AL: begin
                w_regWre = 1'b1;
                w_pcWre  = 1'b1;
            end
            ST_WB_LD: begin
                w_regWre = 1'b1;
                ALUM2Reg = 1'b1;
                w_pcWre  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_inExec = (r_state == ST_EXE_AL) || (r_state == ST_EXE_BR) ||
                      (r_state == ST_EXE_MA) || (r_state == ST_MEM)    ||
                      (r_state == ST_WB_AL)  || (r_state == ST_WB_LD);

    // State-changing enables are killed combinationally so an aborted
    // instruction cannot commit anything in the reset cycle.
    assign PCWre     = w_pcWre     & ~reset;
    assign IRWre     = w_irWre     & ~reset;
    assign RegWre    = w_regWre    & ~reset;
    assign DataMemRW = w_dataMemRW & ~reset;

    assign ALUOp      = w_inExec ? w_decAluOp   : c_aluAdd;
    assign ALUSrcB    = w_inExec ? w_decAluSrcB : 1'b0;
    assign RegOut     = w_inExec ? w_decRegOut  : 1'b0;
    assign ExtSel     = w_inExec ? w_decExtSel  : 1'b1;

    assign state      = r_state;
    assign halted     = (r_state == ST_HALT);
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire
